datapath_fetch: RTL and testbench
=================================

Name: datapath_fetch

Overview:
Instruction-fetch stage of the 5-stage 16-bit pipeline; produces the IF_ID bundle consumed by the decode/RF-read stage.
- Owns the PC and drives the synchronous instruction-memory read port.
- Memory returns the instruction one cycle later on i_pc_rddata, aligned with IF_ID.
- Handles stall, EX-stage redirect (squash) and halt.

Parameters:
RESET_PC, 16'h0000, byte address fetched first after reset
PC_STEP, 2, byte increment per sequential fetch (16-bit instructions)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
o_pc_addr  output  16  instruction-memory byte address issued this cycle
o_pc_rd  output  1  instruction-memory read enable
i_stall  input  1  hold fetch; decode cannot accept a new instruction
i_pc_wr  input  1  redirect from EX (taken branch/jump/call)
i_pc_wrdata  input  16  redirect target byte address
i_halt  input  1  stop fetching until reset
IF_ID  output  IF_ID_WIDTH (33)  {valid[32], PC[31:16], PC+PC_STEP[15:0]}
o_halted  output  1  fetch is in HALTED state

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and is sampled only on posedge clk.
- Reset values:
  - pc_reg = RESET_PC; state = BOOT
  - IF_ID = '0 (valid=0)
  - o_pc_rd = 0; o_halted = 0
  - o_pc_addr = RESET_PC
- Address and read enable:
  - o_pc_addr is combinational from pc_reg.
  - o_pc_rd = 1 in BOOT and RUN, 0 in HALTED.
  - o_pc_rd is held at 1 during stall so memory re-presents the same word.
- FSM states BOOT, RUN, HALTED:
  - BOOT: one cycle after reset. Issues RESET_PC. IF_ID <= valid 0, because no memory data is yet valid. Next state RUN; pc_reg <= RESET_PC+PC_STEP.
  - RUN, normal step (no stall, no redirect): IF_ID <= {1, pc_reg, pc_reg+PC_STEP}; pc_reg <= pc_reg+PC_STEP.
  - RUN, i_stall=1 and i_pc_wr=0: pc_reg and IF_ID hold. The address is re-issued, so i_pc_rddata stays stable for decode.
  - RUN, i_pc_wr=1: pc_reg <= i_pc_wrdata; IF_ID <= valid 0 (wrong-path word squashed), PC fields still updated. Redirect overrides stall. Squashing the older entry already in decode is EX's responsibility.
  - RUN, i_halt=1 (lower priority than redirect): next state HALTED; IF_ID <= valid 0.
  - HALTED: pc_reg and IF_ID hold with valid 0; o_halted=1. Only reset exits HALTED.
- Latency: address issued in cycle N; the instruction and its IF_ID entry are visible to decode in cycle N+1.
- Arithmetic: 16-bit modular. 16'hFFFE + 2 wraps to 16'h0000, valid stays 1.
- Redirect target is used as-is. An odd target is not checked; bit 0 is forwarded unchanged.
- Priority: reset > i_pc_wr > i_halt > i_stall > sequential step.
- Reset asserted mid-stall or mid-redirect: the next cycle is BOOT at RESET_PC, and all pending state is discarded.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs o_fetch_count[31:0] (increments each cycle IF_ID is written with valid=1) and o_squash_count[31:0] (increments each accepted redirect).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, with zero area impact.

Decomposition:
- definesPkg gets:
  - IF_ID_WIDTH=33
  - field indices IF_ID_VALID_BIT=32, IF_ID_PC_MSB=31 / LSB=16, IF_ID_PCN_MSB=15 / LSB=0
  - typedef enum logic [1:0] fetch_state_t {BOOT, RUN, HALTED}
- Sub-module fetch_perf_counters (instantiated only under FETCH_PERF_CNT_EN); everything else stays in one module.

Test Plan:
1. Reset, then 4 free-running cycles → o_pc_addr 0000, 0002, 0004, 0006. IF_ID valid 0 in BOOT. Then {1,0000,0002}, {1,0002,0004}.
2. i_stall=1 for 3 cycles at pc_reg=0008 → o_pc_addr stays 0008, IF_ID frozen, o_pc_rd=1. Release → 000A next.
3. i_pc_wr=1, i_pc_wrdata=0040 while at 0010 → next o_pc_addr=0040 and IF_ID valid=0. Following entry {1,0040,0042}.
4. i_pc_wr=1 (target 0100) and i_stall=1 in the same cycle → redirect wins: o_pc_addr=0100, IF_ID valid 0.
5. RESET_PC=FFFC, run 3 cycles → addresses FFFC, FFFE, 0000. IF_ID {1,FFFE,0000} valid.
6. i_halt=1 → o_halted=1, o_pc_rd=0, IF_ID valid stays 0 for 10 cycles. reset → BOOT at RESET_PC. With FETCH_PERF_CNT_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/datapath_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: IF_ID bundle layout and FSM states.
package datapath_fetch_pkg;

    localparam int IF_ID_WIDTH     = 33;
    localparam int IF_ID_VALID_BIT = 32;
    localparam int IF_ID_PC_MSB    = 31;
    localparam int IF_ID_PC_LSB    = 16;
    localparam int IF_ID_PCN_MSB   = 15;
    localparam int IF_ID_PCN_LSB   = 0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/datapath_fetch_perf_counters.sv
// Fetch/squash event counters for the fetch stage; only built with FETCH_PERF_CNT_EN.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc_i,
    input  logic        squash_inc_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] squash_count_o
);

    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] squash_count_q, squash_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        squash_count_d = squash_count_q;
        if (fetch_inc_i) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (squash_inc_i) begin
            squash_count_d = squash_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            squash_count_q <= squash_count_d;
        end
    end

    assign fetch_count_o  = fetch_count_q;
    assign squash_count_o = squash_count_q;

endmodule

// File: rtl/datapath_fetch.sv
// Instruction-fetch stage: owns the PC, drives the sync imem read port, builds IF_ID.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
//
// state  | meaning
// BOOT   | first cycle after reset, RESET_PC on the bus
// RUN    | sequential fetch, honours stall / redirect / halt
// HALTED | fetch stopped, read disabled; only reset leaves
module datapath_fetch
    import datapath_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [15:0]            o_pc_addr,
    output logic                   o_pc_rd,
    input  logic                   i_stall,
    input  logic                   i_pc_wr,
    input  logic [15:0]            i_pc_wrdata,
    input  logic                   i_halt,
    output logic [IF_ID_WIDTH-1:0] IF_ID,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]            o_fetch_count,
    output logic [31:0]            o_squash_count,
`endif
    output logic                   o_halted
);

    fetch_state_t           state_q, state_d;
    logic [15:0]            pc_q, pc_d;
    logic [15:0]            pc_next;
    logic [IF_ID_WIDTH-1:0] if_id_q, if_id_d;
    logic                   step_en;
    logic                   squash_en;

    assign pc_next = pc_q + PC_STEP;

    // IF_ID written at the edge closing the issue cycle lines up with the returning word.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_id_d   = if_id_q;
        step_en   = 1'b0;
        squash_en = 1'b0;
        case (state_q)
            BOOT, RUN: begin
                if (i_pc_wr) begin
                    pc_d      = i_pc_wrdata;
                    if_id_d   = {1'b0, pc_q, pc_next};
                    state_d   = RUN;
                    squash_en = 1'b1;
                end else if (i_halt) begin
                    if_id_d[IF_ID_VALID_BIT] = 1'b0;
                    state_d                  = HALTED;
                end else if (!i_stall) begin
                    pc_d    = pc_next;
                    if_id_d = {1'b1, pc_q, pc_next};
                    state_d = RUN;
                    step_en = 1'b1;
                end
            end
            HALTED: begin
                if_id_d[IF_ID_VALID_BIT] = 1'b0;
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
                if_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            if_id_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign o_pc_addr = pc_q;
    assign o_pc_rd   = !reset && (state_q != HALTED);
    assign o_halted  = !reset && (state_q == HALTED);
    assign IF_ID     = if_id_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clk            (clk),
        .reset          (reset),
        .fetch_inc_i    (step_en),
        .squash_inc_i   (squash_en),
        .fetch_count_o  (o_fetch_count),
        .squash_count_o (o_squash_count)
    );
`else
    logic unused_perf;
    assign unused_perf = step_en ^ squash_en;
`endif

endmodule

// File: tb/tb_datapath_fetch.sv
// Directed self-checking bench for datapath_fetch; second instance covers PC wrap-around.
module tb_datapath_fetch;

    logic        clk;
    logic        reset, reset_w;
    logic        i_stall, i_pc_wr, i_halt;
    logic [15:0] i_pc_wrdata;
    logic        zero_w;
    logic [15:0] zero16_w;

    logic [15:0] o_pc_addr, w_pc_addr;
    logic        o_pc_rd, w_pc_rd;
    logic [32:0] IF_ID, w_if_id;
    logic        o_halted, w_halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_count, o_squash_count, w_fetch_count, w_squash_count;
`endif

    int checks;
    int fails;

    datapath_fetch #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .o_pc_addr   (o_pc_addr),
        .o_pc_rd     (o_pc_rd),
        .i_stall     (i_stall),
        .i_pc_wr     (i_pc_wr),
        .i_pc_wrdata (i_pc_wrdata),
        .i_halt      (i_halt),
        .IF_ID       (IF_ID),
`ifdef FETCH_PERF_CNT_EN
        .o_fetch_count  (o_fetch_count),
        .o_squash_count (o_squash_count),
`endif
        .o_halted    (o_halted)
    );

    datapath_fetch #(.RESET_PC(16'hFFFC), .PC_STEP(16'd2)) u_wrap (
        .clk         (clk),
        .reset       (reset_w),
        .o_pc_addr   (w_pc_addr),
        .o_pc_rd     (w_pc_rd),
        .i_stall     (zero_w),
        .i_pc_wr     (zero_w),
        .i_pc_wrdata (zero16_w),
        .i_halt      (zero_w),
        .IF_ID       (w_if_id),
`ifdef FETCH_PERF_CNT_EN
        .o_fetch_count  (w_fetch_count),
        .o_squash_count (w_squash_count),
`endif
        .o_halted    (w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (o_pc_rd !== 1'b0) begin
            fails++; $display("FAIL reset_pc_rd got=%0b exp=0", o_pc_rd);
        end
        checks++;
        if (o_pc_addr !== 16'h0000 || IF_ID !== 33'h0 || o_halted !== 1'b0) begin
            fails++; $display("FAIL reset_state got addr=%h if_id=%h halted=%0b exp addr=0000 if_id=0 halted=0",
                              o_pc_addr, IF_ID, o_halted);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (o_pc_addr !== 16'h0000 || o_pc_rd !== 1'b1 || IF_ID[32] !== 1'b0) begin
            fails++; $display("FAIL boot got addr=%h rd=%0b valid=%0b exp addr=0000 rd=1 valid=0",
                              o_pc_addr, o_pc_rd, IF_ID[32]);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (o_fetch_count !== 32'd0 || o_squash_count !== 32'd0) begin
            fails++; $display("FAIL reset_counters got fetch=%0d squash=%0d exp 0 0", o_fetch_count, o_squash_count);
        end
`endif
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr [4];
        logic [32:0] exp_ifid [4];
        exp_addr = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
        exp_ifid = '{{1'b1, 16'h0000, 16'h0002}, {1'b1, 16'h0002, 16'h0004},
                     {1'b1, 16'h0004, 16'h0006}, {1'b1, 16'h0006, 16'h0008}};
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_pc_addr !== exp_addr[i] || IF_ID !== exp_ifid[i]) begin
                fails++; $display("FAIL seq[%0d] got addr=%h if_id=%h exp addr=%h if_id=%h",
                                  i, o_pc_addr, IF_ID, exp_addr[i], exp_ifid[i]);
            end
        end
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_pc_addr !== 16'h0008 || IF_ID !== {1'b1, 16'h0006, 16'h0008} || o_pc_rd !== 1'b1) begin
                fails++; $display("FAIL stall[%0d] got addr=%h if_id=%h rd=%0b exp addr=0008 if_id=10006_0008 rd=1",
                                  i, o_pc_addr, IF_ID, o_pc_rd);
            end
        end
        i_stall = 1'b0;
        step();
        checks++;
        if (o_pc_addr !== 16'h000A || IF_ID !== {1'b1, 16'h0008, 16'h000A}) begin
            fails++; $display("FAIL stall_release got addr=%h if_id=%h exp addr=000a if_id=10008_000a",
                              o_pc_addr, IF_ID);
        end
    endtask

    task automatic test_redirect();
        step(); step(); step();
        checks++;
        if (o_pc_addr !== 16'h0010) begin
            fails++; $display("FAIL pre_redirect got addr=%h exp 0010", o_pc_addr);
        end
        i_pc_wr = 1'b1; i_pc_wrdata = 16'h0040;
        step();
        i_pc_wr = 1'b0;
        checks++;
        if (o_pc_addr !== 16'h0040 || IF_ID !== {1'b0, 16'h0010, 16'h0012}) begin
            fails++; $display("FAIL redirect got addr=%h if_id=%h exp addr=0040 if_id=00010_0012",
                              o_pc_addr, IF_ID);
        end
        step();
        checks++;
        if (o_pc_addr !== 16'h0042 || IF_ID !== {1'b1, 16'h0040, 16'h0042}) begin
            fails++; $display("FAIL post_redirect got addr=%h if_id=%h exp addr=0042 if_id=10040_0042",
                              o_pc_addr, IF_ID);
        end
    endtask

    task automatic test_redirect_over_stall();
        i_pc_wr = 1'b1; i_pc_wrdata = 16'h0100; i_stall = 1'b1;
        step();
        i_pc_wr = 1'b0; i_stall = 1'b0;
        checks++;
        if (o_pc_addr !== 16'h0100 || IF_ID !== {1'b0, 16'h0042, 16'h0044}) begin
            fails++; $display("FAIL redirect_stall got addr=%h if_id=%h exp addr=0100 if_id=00042_0044",
                              o_pc_addr, IF_ID);
        end
        step();
        checks++;
        if (o_pc_addr !== 16'h0102 || IF_ID !== {1'b1, 16'h0100, 16'h0102}) begin
            fails++; $display("FAIL after_redirect_stall got addr=%h if_id=%h exp addr=0102 if_id=10100_0102",
                              o_pc_addr, IF_ID);
        end
    endtask

    task automatic test_odd_target();
        i_pc_wr = 1'b1; i_pc_wrdata = 16'h0033;
        step();
        i_pc_wr = 1'b0;
        step();
        checks++;
        if (o_pc_addr !== 16'h0035 || IF_ID !== {1'b1, 16'h0033, 16'h0035}) begin
            fails++; $display("FAIL odd_target got addr=%h if_id=%h exp addr=0035 if_id=10033_0035",
                              o_pc_addr, IF_ID);
        end
    endtask

    task automatic test_halt();
        i_halt = 1'b1;
        step();
        i_halt = 1'b0;
        checks++;
        if (o_halted !== 1'b1 || o_pc_rd !== 1'b0 || IF_ID !== {1'b0, 16'h0033, 16'h0035} || o_pc_addr !== 16'h0035) begin
            fails++; $display("FAIL halt_entry got halted=%0b rd=%0b if_id=%h addr=%h exp 1 0 00033_0035 0035",
                              o_halted, o_pc_rd, IF_ID, o_pc_addr);
        end
        for (int i = 0; i < 10; i++) begin
            i_pc_wr     = (i == 3);
            i_pc_wrdata = 16'h0200;
            step();
            checks++;
            if (o_halted !== 1'b1 || o_pc_rd !== 1'b0 || IF_ID[32] !== 1'b0 || o_pc_addr !== 16'h0035) begin
                fails++; $display("FAIL halt_hold[%0d] got halted=%0b rd=%0b valid=%0b addr=%h exp 1 0 0 0035",
                                  i, o_halted, o_pc_rd, IF_ID[32], o_pc_addr);
            end
        end
        i_pc_wr = 1'b0;
        test_reset();
        checks++;
        if (o_halted !== 1'b0) begin
            fails++; $display("FAIL halt_exit got halted=%0b exp 0", o_halted);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(); step();
        i_stall = 1'b1; i_pc_wr = 1'b1; i_pc_wrdata = 16'h0400;
        reset = 1'b1;
        step();
        reset = 1'b0; i_stall = 1'b0; i_pc_wr = 1'b0;
        #1;
        checks++;
        if (o_pc_addr !== 16'h0000 || IF_ID !== 33'h0 || o_pc_rd !== 1'b1) begin
            fails++; $display("FAIL reset_mid_stall got addr=%h if_id=%h rd=%0b exp 0000 0 1",
                              o_pc_addr, IF_ID, o_pc_rd);
        end
        step();
        checks++;
        if (o_pc_addr !== 16'h0002 || IF_ID !== {1'b1, 16'h0000, 16'h0002}) begin
            fails++; $display("FAIL reset_mid_stall_run got addr=%h if_id=%h exp 0002 10000_0002",
                              o_pc_addr, IF_ID);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [4];
        logic [32:0] exp_ifid [4];
        exp_addr = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        exp_ifid = '{33'h0, {1'b1, 16'hFFFC, 16'hFFFE}, {1'b1, 16'hFFFE, 16'h0000}, {1'b1, 16'h0000, 16'h0002}};
        reset_w = 1'b1;
        step();
        reset_w = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (w_pc_addr !== exp_addr[i] || w_if_id !== exp_ifid[i]) begin
                fails++; $display("FAIL wrap[%0d] got addr=%h if_id=%h exp addr=%h if_id=%h",
                                  i, w_pc_addr, w_if_id, exp_addr[i], exp_ifid[i]);
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b1; reset_w = 1'b1;
        i_stall = 1'b0; i_pc_wr = 1'b0; i_halt = 1'b0; i_pc_wrdata = 16'h0000;
        zero_w = 1'b0; zero16_w = 16'h0000;
        step();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_odd_target();
        test_halt();
        test_reset_mid_stall();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
